// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: clock rate, frame format and receiver state encoding.
// The frame format constants are common to the transmitter and receiver.
package uart_rx_pkg;

  localparam logic [25:0] CLK_FREQ   = 26'd50_000_000;
  localparam int          CNT_W      = 13;
  localparam int          DATA_BITS  = 8;
  localparam logic        PARITY_ODD = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_baud_div.sv
// Registered bit-time divider: bit_time = CLK_FREQ/baud_rate - 1 and half = bit_time/2,
// both captured when load is high. Results too large for CNT_W saturate.
module uart_baud_div #(
  parameter logic [25:0] CLK_FREQ = uart_rx_pkg::CLK_FREQ,
  parameter int          CNT_W    = uart_rx_pkg::CNT_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic [16:0]      baud_rate,
  output logic [CNT_W-1:0] bit_time,
  output logic [CNT_W-1:0] half
);

  localparam logic [25:0] CNT_MAX = 26'((1 << CNT_W) - 1);

  logic [25:0]      divisor;
  logic [25:0]      quotient;
  logic [25:0]      minus_one;
  logic [CNT_W-1:0] bit_time_next;

  // A zero divisor never reaches the registers (load is gated), but keep the divide defined.
  always_comb begin
    divisor       = (baud_rate == '0) ? 26'd1 : {9'd0, baud_rate};
    quotient      = CLK_FREQ / divisor;
    minus_one     = (quotient == '0) ? '0 : quotient - 26'd1;
    bit_time_next = (minus_one > CNT_MAX) ? '1 : minus_one[CNT_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      bit_time <= '0;
      half     <= '0;
    end else if (load) begin
      bit_time <= bit_time_next;
      half     <= bit_time_next >> 1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, odd parity, stop. Mid-bit sampling with a
// runtime baud rate; parity errors qualify data_valid, framing errors pulse frame_err.
module uart_rx #(
  parameter logic [25:0] CLK_FREQ = uart_rx_pkg::CLK_FREQ,
  parameter int          CNT_W    = uart_rx_pkg::CNT_W
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [16:0] baud_rate,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  import uart_rx_pkg::*;

  localparam int BIT_W = $clog2(DATA_BITS);

  logic                 rx_meta_reg, rx_s_reg, rx_s_d_reg;
  logic [2:0]           fill_reg;
  logic                 start_edge, load;
  logic [CNT_W-1:0]     bit_time, half;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BIT_W-1:0]     bit_num_reg, bit_num_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic [7:0]           data_reg, data_next;
  logic                 dv_reg, dv_next;
  logic                 pe_reg, pe_next;
  logic                 fe_reg, fe_next;

  // fill_reg marks when all three sync stages hold real line samples, so a line
  // that is already low when reset releases does not look like a start edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_s_d_reg  <= 1'b1;
      fill_reg    <= 3'b000;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_s_d_reg  <= rx_s_reg;
      fill_reg    <= {fill_reg[1:0], 1'b1};
    end
  end

  assign start_edge = fill_reg[2] & rx_s_d_reg & ~rx_s_reg & (baud_rate != '0);
  assign load       = (state_reg == IDLE) & start_edge;

  uart_baud_div #(
    .CLK_FREQ (CLK_FREQ),
    .CNT_W    (CNT_W)
  ) u_baud_div (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .load      (load),
    .baud_rate (baud_rate),
    .bit_time  (bit_time),
    .half      (half)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_num_reg <= '0;
      shift_reg   <= '0;
      par_reg     <= 1'b0;
      data_reg    <= '0;
      dv_reg      <= 1'b0;
      pe_reg      <= 1'b0;
      fe_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_num_reg <= bit_num_next;
      shift_reg   <= shift_next;
      par_reg     <= par_next;
      data_reg    <= data_next;
      dv_reg      <= dv_next;
      pe_reg      <= pe_next;
      fe_reg      <= fe_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = (cnt_reg == bit_time) ? '0 : cnt_reg + 1'b1;
    bit_num_next = bit_num_reg;
    shift_next   = shift_reg;
    par_next     = par_reg;
    data_next    = data_reg;
    dv_next      = 1'b0;
    pe_next      = pe_reg;
    fe_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (start_edge) state_next = START;
      end
      // Re-check the line at mid start bit to reject glitches.
      START: begin
        if (cnt_reg == half) begin
          cnt_next     = '0;
          bit_num_next = '0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == bit_time) begin
          shift_next[bit_num_reg] = rx_s_reg;
          if (bit_num_reg == BIT_W'(DATA_BITS - 1)) state_next = PARITY;
          else bit_num_next = bit_num_reg + 1'b1;
        end
      end
      PARITY: begin
        if (cnt_reg == bit_time) begin
          par_next   = rx_s_reg;
          state_next = STOP;
        end
      end
      // Leaving at mid-stop lets a back-to-back start edge be caught immediately.
      STOP: begin
        if (cnt_reg == bit_time) begin
          if (rx_s_reg) begin
            data_next  = shift_reg;
            dv_next    = 1'b1;
            pe_next    = ((^shift_reg) ^ par_reg) != PARITY_ODD;
            state_next = IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rx_s_reg) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign data       = data_reg;
  assign data_valid = dv_reg;
  assign parity_err = pe_reg;
  assign frame_err  = fe_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are bit-banged onto rx at 50 MHz and the
// received bytes/flags are checked against hand-computed values.
module tb_uart_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [16:0] baud_rate = 17'd115200;
  logic        rx = 1'b1;
  logic [7:0]  data;
  logic        data_valid, parity_err, frame_err, busy;

  int checks = 0;
  int errors = 0;

  int         dv_cycles = 0;
  int         fe_cycles = 0;
  logic [7:0] rx_q[$];
  logic       pe_q[$];

  localparam int P115 = 434;  // cycles per bit at 115200
  localparam int P125 = 400;  // cycles per bit at 125000

  uart_rx dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .baud_rate  (baud_rate),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (data_valid) begin
      dv_cycles++;
      rx_q.push_back(data);
      pe_q.push_back(parity_err);
    end
    if (frame_err) fe_cycles++;
  end

  task automatic clear_mon();
    dv_cycles = 0;
    fe_cycles = 0;
    rx_q.delete();
    pe_q.delete();
  endtask

  // Must be called at a negedge; returns at a negedge with rx left at the stop value.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stop, input int period);
    logic [10:0] f;
    f = {stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (period) @(negedge sys_clk);
    end
  endtask

  function automatic logic [7:0] q_data(input int i);
    return (rx_q.size() > i) ? rx_q[i] : 8'hxx;
  endfunction

  function automatic logic q_pe(input int i);
    return (pe_q.size() > i) ? pe_q[i] : 1'bx;
  endfunction

  task automatic test_reset();
    sys_rst = 1'b1;
    rx = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", data_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_pe got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    repeat (10) @(negedge sys_clk);
    $display("reset: done");
  endtask

  task automatic test_loopback();
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b1, P115);
    repeat (10) @(negedge sys_clk);
    checks++; if (dv_cycles !== 1) begin errors++; $display("FAIL loop_dv_cycles got %0d want 1", dv_cycles); end
    checks++; if (q_data(0) !== 8'hA5) begin errors++; $display("FAIL loop_byte got %h want a5", q_data(0)); end
    checks++; if (q_pe(0) !== 1'b0) begin errors++; $display("FAIL loop_pe got %b want 0", q_pe(0)); end
    checks++; if (fe_cycles !== 0) begin errors++; $display("FAIL loop_fe got %0d want 0", fe_cycles); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL loop_held got %h want a5", data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy got %b want 0", busy); end
    $display("loopback: byte a5 received %h", q_data(0));
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    logic       par   [6];
    bytes = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFE, 8'hFF};
    par   = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    baud_rate = 17'd125000;
    repeat (5) @(negedge sys_clk);
    clear_mon();
    for (int i = 0; i < 6; i++) send_frame(bytes[i], par[i], 1'b1, P125);
    repeat (10) @(negedge sys_clk);
    checks++; if (dv_cycles !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", dv_cycles); end
    checks++; if (fe_cycles !== 0) begin errors++; $display("FAIL b2b_fe got %0d want 0", fe_cycles); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (q_data(i) !== bytes[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, q_data(i), bytes[i]); end
      checks++; if (q_pe(i) !== 1'b0) begin errors++; $display("FAIL b2b_pe%0d got %b want 0", i, q_pe(i)); end
      $display("back_to_back: frame %0d byte %h", i, q_data(i));
    end
    baud_rate = 17'd115200;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_glitch();
    int busy_cycles;
    busy_cycles = 0;
    clear_mon();
    rx = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge sys_clk);
      if (busy) busy_cycles++;
      if (n == 99) rx = 1'b1;
    end
    checks++; if (busy_cycles < 214 || busy_cycles > 220) begin errors++; $display("FAIL glitch_busy_len got %0d want 214..220", busy_cycles); end
    checks++; if (dv_cycles !== 0) begin errors++; $display("FAIL glitch_dv got %0d want 0", dv_cycles); end
    checks++; if (fe_cycles !== 0) begin errors++; $display("FAIL glitch_fe got %0d want 0", fe_cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL glitch_data_held got %h want ff", data); end
    $display("glitch: busy for %0d cycles", busy_cycles);
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h96, 1'b1, 1'b0, P115);
    repeat (20 * P115) @(negedge sys_clk);
    checks++; if (fe_cycles !== 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", fe_cycles); end
    checks++; if (dv_cycles !== 0) begin errors++; $display("FAIL ferr_dv got %0d want 0", dv_cycles); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low got %b want 1", busy); end
    checks++; if (data !== 8'hFF) begin errors++; $display("FAIL ferr_data_held got %h want ff", data); end
    rx = 1'b1;
    repeat (8) @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_high got %b want 0", busy); end
    $display("frame_error: frame_err cycles %0d", fe_cycles);
  endtask

  task automatic test_parity_error();
    clear_mon();
    send_frame(8'h00, 1'b0, 1'b1, P115);
    send_frame(8'hC3, 1'b0, 1'b1, P115);
    repeat (10) @(negedge sys_clk);
    checks++; if (dv_cycles !== 2) begin errors++; $display("FAIL perr_count got %0d want 2", dv_cycles); end
    checks++; if (q_data(0) !== 8'h00) begin errors++; $display("FAIL perr_byte0 got %h want 00", q_data(0)); end
    checks++; if (q_pe(0) !== 1'b1) begin errors++; $display("FAIL perr_flag0 got %b want 1", q_pe(0)); end
    checks++; if (q_data(1) !== 8'hC3) begin errors++; $display("FAIL perr_byte1 got %h want c3", q_data(1)); end
    checks++; if (q_pe(1) !== 1'b1) begin errors++; $display("FAIL perr_flag1 got %b want 1", q_pe(1)); end
    checks++; if (fe_cycles !== 0) begin errors++; $display("FAIL perr_fe got %0d want 0", fe_cycles); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL perr_held got %b want 1", parity_err); end
    $display("parity_error: bytes %h %h", q_data(0), q_data(1));
  endtask

  task automatic test_midframe_reset();
    clear_mon();
    rx = 1'b0;
    repeat (5 * P115 + 217) @(negedge sys_clk);  // start + bits 0..3 + half of bit 4
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL mrst_data got %h want 00", data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL mrst_pe got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL mrst_dv got %b want 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mrst_fe got %b want 0", frame_err); end
    repeat (P115 - 219 + 3 * P115) @(negedge sys_clk);  // rest of bit 4, bits 5..7
    rx = 1'b1;
    repeat (3 * P115) @(negedge sys_clk);               // parity, stop, idle
    checks++; if (dv_cycles !== 0) begin errors++; $display("FAIL mrst_partial_dv got %0d want 0", dv_cycles); end
    checks++; if (fe_cycles !== 0) begin errors++; $display("FAIL mrst_partial_fe got %0d want 0", fe_cycles); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_partial_busy got %b want 0", busy); end
    send_frame(8'h3C, 1'b1, 1'b1, P115);
    repeat (10) @(negedge sys_clk);
    checks++; if (dv_cycles !== 1) begin errors++; $display("FAIL mrst_next_count got %0d want 1", dv_cycles); end
    checks++; if (q_data(0) !== 8'h3C) begin errors++; $display("FAIL mrst_next_byte got %h want 3c", q_data(0)); end
    checks++; if (q_pe(0) !== 1'b0) begin errors++; $display("FAIL mrst_next_pe got %b want 0", q_pe(0)); end
    $display("midframe_reset: next byte %h", q_data(0));
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_parity_error();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
